// File: rtl/vga_pkg.sv
// Shared constants, state encoding and frame-size helper for the VGA frame fetch path.
package vga_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int WORD_BYTES   = 16;
    localparam int PIX_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        REQ,
        DATA
    } fetch_state_t;

    function automatic int words_per_frame(input int h_active, input int v_active);
        return (h_active * v_active) / PIX_PER_WORD;
    endfunction
endpackage

// File: rtl/vga_fetch_addr_gen.sv
// Frame addressing for the fetch master: base latch, word/beat counters and
// the end-of-burst / end-of-frame flags.
module vga_fetch_addr_gen
    import vga_pkg::*;
#(
    parameter int WORDS_PER_FRAME = 76800,
    parameter int BURST_LEN       = 16,
    parameter int WCNT_W          = 17
) (
    input  logic        vga_clk,
    input  logic        vga_reset_n,
    input  logic        start,
    input  logic        issue,
    input  logic        beat,
    input  logic [31:0] frame_base,
    output logic [31:0] cur_addr,
    output logic        last_beat,
    output logic        last_word
);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [31:0]       base_q;
    logic [WCNT_W-1:0] word_cnt;
    logic [BEAT_W-1:0] beat_cnt;

    assign last_beat = (beat_cnt == BEAT_W'(BURST_LEN - 1));
    assign last_word = (word_cnt == WCNT_W'(WORDS_PER_FRAME - 1));

    // word_cnt only moves in whole bursts between requests, so base plus the
    // word offset is exactly the running burst address; it wraps at 2^32.
    assign cur_addr = base_q + (32'(word_cnt) * 32'(WORD_BYTES));

    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            base_q   <= '0;
            word_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            if (start) begin
                base_q   <= frame_base;
                word_cnt <= '0;
            end else if (beat) begin
                if (last_word) begin
                    base_q   <= frame_base;
                    word_cnt <= '0;
                end else begin
                    word_cnt <= word_cnt + WCNT_W'(1);
                end
            end

            if (issue)
                beat_cnt <= '0;
            else if (beat)
                beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end
endmodule

// File: rtl/vga_frame_fetch.sv
// Burst read master that streams frame buffer words from DDR into the VGA
// pixel FIFO, one outstanding burst at a time, wrapping frame to frame.
module vga_frame_fetch
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 256,
    parameter int FIFO_AW    = 8
) (
    input  logic               vga_clk,
    input  logic               vga_reset_n,
    input  logic               enable,
    input  logic [31:0]        frame_base,
    output logic [31:0]        avm_address,
    output logic               avm_read,
    output logic [7:0]         avm_burstcount,
    input  logic               avm_waitrequest,
    input  logic [127:0]       avm_readdata,
    input  logic               avm_readdatavalid,
    input  logic [FIFO_AW:0]   fifo_usedw,
    output logic               fifo_wr_en,
    output logic [127:0]       fifo_wr_data,
    output logic               frame_done,
    output logic               busy
);
    localparam int WORDS_PER_FRAME = words_per_frame(H_ACTIVE, V_ACTIVE);
    localparam int WCNT_W          = $clog2(WORDS_PER_FRAME + 1);
    // Two words of slack: one for the registered write, one for usedw lag.
    localparam logic [FIFO_AW:0] SPACE_LIM = (FIFO_AW + 1)'(FIFO_DEPTH - BURST_LEN - 2);

    fetch_state_t state, state_nxt;
    logic         start, issue, beat;
    logic         last_beat, last_word;
    logic [31:0]  cur_addr;

    assign start = (state == IDLE) && enable;
    assign issue = (state == REQ) && !avm_waitrequest;
    assign beat  = (state == DATA) && avm_readdatavalid;

    vga_fetch_addr_gen #(
        .WORDS_PER_FRAME (WORDS_PER_FRAME),
        .BURST_LEN       (BURST_LEN),
        .WCNT_W          (WCNT_W)
    ) u_addr_gen (
        .vga_clk     (vga_clk),
        .vga_reset_n (vga_reset_n),
        .start       (start),
        .issue       (issue),
        .beat        (beat),
        .frame_base  (frame_base),
        .cur_addr    (cur_addr),
        .last_beat   (last_beat),
        .last_word   (last_word)
    );

    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        avm_read       = 1'b0;
        avm_address    = '0;
        avm_burstcount = '0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (enable)
                    state_nxt = WAIT_SPACE;
            end
            WAIT_SPACE: begin
                if (!enable)
                    state_nxt = IDLE;
                else if (fifo_usedw <= SPACE_LIM)
                    state_nxt = REQ;
            end
            REQ: begin
                // enable is deliberately ignored: a posted request is never withdrawn.
                avm_read       = 1'b1;
                avm_address    = cur_addr;
                avm_burstcount = 8'(BURST_LEN);
                if (!avm_waitrequest)
                    state_nxt = DATA;
            end
            DATA: begin
                if (beat && last_beat)
                    state_nxt = enable ? WAIT_SPACE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Return data outside DATA (e.g. stragglers after a reset) never reaches the FIFO.
    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            frame_done   <= 1'b0;
        end else begin
            fifo_wr_en <= beat;
            frame_done <= beat && last_word;
            if (beat)
                fifo_wr_data <= avm_readdata;
        end
    end
endmodule
